// File: rtl/keccak_pkg.sv
// ============================================================================
// Module      : keccak_pkg
// Description : Shared constants and state encoding for the SHAKE absorb path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keccak_pkg;

    localparam int RATE_LANES_128 = 21;
    localparam int RATE_LANES_256 = 17;

    localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LEN,
        ABSORB,
        PAD_FINAL,
        PERMUTE,
        DONE
    } absorb_state_t;

endpackage

`default_nettype wire

// File: rtl/size_counter.sv
// ============================================================================
// Module      : size_counter
// Description : Remaining-bit counter; loads a length, counts down by a step
//               and saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module size_counter #(
    parameter int WIDTH = 32,
    parameter int W     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_write,
    input  logic [WIDTH-1:0]     write_data,
    input  logic                 en_count,
    input  logic [$clog2(W):0]   step_size,
    input  logic [WIDTH-1:0]     block_size,
    output logic [WIDTH-1:0]     counter,
    output logic                 last_block
);

    logic [WIDTH-1:0] w_step;

    assign w_step     = WIDTH'(step_size);
    assign last_block = (counter <= block_size);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '1;
        end else if (en_write) begin
            counter <= write_data;
        end else if (en_count) begin
            counter <= (counter > w_step) ? (counter - w_step) : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/absorb_controller.sv
// ============================================================================
// Module      : absorb_controller
// Description : Streams one SHAKE message into the rate lanes, applies the
//               SHAKE padding and hands each full block to the permutation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module absorb_controller
    import keccak_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int W     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [W-1:0]     lane_data,
    output logic [4:0]       lane_idx,
    output logic             lane_we,
    output logic             perm_start,
    input  logic             perm_done,
    output logic             busy,
    output logic             done
);

    localparam int SH = $clog2(W);

    localparam logic [2:0] S_IDLE      = 3'(IDLE);
    localparam logic [2:0] S_LOAD_LEN  = 3'(LOAD_LEN);
    localparam logic [2:0] S_ABSORB    = 3'(ABSORB);
    localparam logic [2:0] S_PAD_FINAL = 3'(PAD_FINAL);
    localparam logic [2:0] S_PERMUTE   = 3'(PERMUTE);
    localparam logic [2:0] S_DONE      = 3'(DONE);

    logic [2:0]       r_state;
    logic [4:0]       r_rate;
    logic [4:0]       r_lane_idx;
    logic             r_pad_done;
    logic             r_perm_first;

    logic [WIDTH-1:0] w_counter;
    logic [WIDTH-1:0] w_block_size;
    logic             w_unused_last_block;
    logic             w_en_write;
    logic             w_en_count;
    logic             w_pad_now;
    logic             w_cnt_zero;
    logic             w_cnt_lt_w;
    logic             w_last_lane;
    logic [SH-1:0]    w_shamt;
    logic [W-1:0]     w_mask;
    logic [W-1:0]     w_pad;

    assign w_block_size = WIDTH'({r_rate, {SH{1'b0}}});
    assign w_cnt_zero   = (w_counter == '0);
    assign w_cnt_lt_w   = (w_counter < WIDTH'(W));
    assign w_last_lane  = (r_lane_idx == (r_rate - 5'd1));
    assign w_shamt      = w_counter[SH-1:0];
    assign w_mask       = (W'(1) << w_shamt) - W'(1);
    assign w_pad        = W'(SHAKE_SUFFIX) << w_shamt;
    assign busy         = (r_state != S_IDLE);

    size_counter #(
        .WIDTH (WIDTH),
        .W     (W)
    ) u_size_counter (
        .clk        (clk),
        .rst        (rst),
        .en_write   (w_en_write),
        .write_data ({din[WIDTH-1:3], 3'b000}),
        .en_count   (w_en_count),
        .step_size  (($clog2(W)+1)'(W)),
        .block_size (w_block_size),
        .counter    (w_counter),
        .last_block (w_unused_last_block)
    );

    always_comb begin
        din_ready  = 1'b0;
        lane_we    = 1'b0;
        lane_data  = '0;
        lane_idx   = r_lane_idx;
        perm_start = 1'b0;
        done       = 1'b0;
        w_en_write = 1'b0;
        w_en_count = 1'b0;
        w_pad_now  = 1'b0;
        case (r_state)
            S_LOAD_LEN: begin
                din_ready  = 1'b1;
                w_en_write = din_valid;
            end
            S_ABSORB: begin
                if (!w_cnt_zero) begin
                    din_ready = 1'b1;
                    if (din_valid) begin
                        lane_we    = 1'b1;
                        w_en_count = 1'b1;
                        if (w_cnt_lt_w) begin
                            // Message ends inside this lane: keep valid bits, append suffix
                            lane_data = (din & w_mask) | w_pad;
                            w_pad_now = 1'b1;
                            if (w_last_lane) begin
                                lane_data[W-1] = 1'b1;
                            end
                        end else begin
                            lane_data = din;
                        end
                    end
                end else if (!r_pad_done) begin
                    lane_we   = 1'b1;
                    lane_data = W'(SHAKE_SUFFIX);
                    w_pad_now = 1'b1;
                    if (w_last_lane) begin
                        lane_data[W-1] = 1'b1;
                    end
                end
            end
            S_PAD_FINAL: begin
                lane_we        = 1'b1;
                lane_idx       = r_rate - 5'd1;
                lane_data[W-1] = 1'b1;
            end
            S_PERMUTE: begin
                perm_start = r_perm_first;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rate       <= 5'(RATE_LANES_128);
            r_lane_idx   <= '0;
            r_pad_done   <= 1'b0;
            r_perm_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rate     <= mode ? 5'(RATE_LANES_256) : 5'(RATE_LANES_128);
                        r_pad_done <= 1'b0;
                        r_state    <= S_LOAD_LEN;
                    end
                end
                S_LOAD_LEN: begin
                    if (din_valid) begin
                        r_lane_idx <= '0;
                        r_state    <= S_ABSORB;
                    end
                end
                S_ABSORB: begin
                    if (lane_we) begin
                        if (w_pad_now) begin
                            r_pad_done <= 1'b1;
                        end
                        if (w_last_lane) begin
                            r_state      <= S_PERMUTE;
                            r_perm_first <= 1'b1;
                        end else if (w_pad_now) begin
                            r_state <= S_PAD_FINAL;
                        end else begin
                            r_lane_idx <= r_lane_idx + 5'd1;
                        end
                    end
                end
                S_PAD_FINAL: begin
                    r_state      <= S_PERMUTE;
                    r_perm_first <= 1'b1;
                end
                S_PERMUTE: begin
                    r_perm_first <= 1'b0;
                    if (perm_done) begin
                        if (r_pad_done) begin
                            r_state <= S_DONE;
                        end else begin
                            r_lane_idx <= '0;
                            r_state    <= S_ABSORB;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_absorb_controller.sv
// ============================================================================
// Module      : tb_absorb_controller
// Description : Scoreboard bench for absorb_controller with a permutation
//               responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_absorb_controller;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
    } lane_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] lane_data;
    logic [4:0]  lane_idx;
    logic        lane_we;
    logic        perm_start;
    logic        perm_done;
    logic        busy;
    logic        done;

    lane_t       exp_q[$];
    logic [63:0] words[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          perm_seen = 0;
    int          perm_delay = 1;
    int          lane_cnt = 0;
    logic [63:0] first_lane = '0;
    logic [63:0] last_lane  = '0;

    absorb_controller #(
        .WIDTH (32),
        .W     (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .lane_data  (lane_data),
        .lane_idx   (lane_idx),
        .lane_we    (lane_we),
        .perm_start (perm_start),
        .perm_done  (perm_done),
        .busy       (busy),
        .done       (done)
    );

    always #10 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane writes are sampled mid-low-phase, after the driver has settled inputs
    always begin
        lane_t e;
        @(negedge clk);
        #3;
        if (!rst && lane_we) begin
            if (exp_q.size() == 0) begin
                chk_val("lane_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk_val("lane_idx", 64'(lane_idx), 64'(e.idx));
                chk_val("lane_data", lane_data, e.data);
            end
            if (lane_cnt == 0) first_lane = lane_data;
            last_lane = lane_data;
            lane_cnt++;
        end
    end

    initial begin
        perm_done = 1'b0;
        forever begin
            @(negedge clk);
            perm_done = 1'b0;
            if (perm_start && !rst) begin
                perm_seen++;
                for (int k = 0; k < perm_delay; k++) begin
                    @(negedge clk);
                    #1;
                    chk_val("perm_din_ready", 64'(din_ready), 64'd0);
                    chk_val("perm_start_pulse", 64'(perm_start), 64'd0);
                end
                perm_done = 1'b1;
            end
        end
    end

    task automatic build_exp(input logic m, input int len, output int perms, output int nlanes);
        int    rate;
        int    rem;
        int    idx;
        int    wi;
        bit    pad;
        lane_t e;
        logic [63:0] d;
        rate = m ? 17 : 21;
        rem  = len & ~7;
        idx  = 0;
        wi   = 0;
        pad  = 1'b0;
        perms  = 0;
        nlanes = 0;
        while (1) begin
            if (rem > 0) begin
                if (rem >= 64) begin
                    d = words[wi];
                end else begin
                    d = (words[wi] & ((64'd1 << rem) - 64'd1)) | (64'h1F << rem);
                    pad = 1'b1;
                    if (idx == rate - 1) d[63] = 1'b1;
                end
                wi++;
                rem = (rem >= 64) ? rem - 64 : 0;
            end else begin
                d = 64'h1F;
                if (idx == rate - 1) d[63] = 1'b1;
                pad = 1'b1;
            end
            e.idx = 5'(idx); e.data = d;
            exp_q.push_back(e);
            nlanes++;
            if (idx == rate - 1) begin
                perms++;
                if (pad) break;
                idx = 0;
            end else if (pad) begin
                e.idx = 5'(rate - 1); e.data = 64'h8000_0000_0000_0000;
                exp_q.push_back(e);
                nlanes++;
                perms++;
                break;
            end else begin
                idx++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer
    task automatic send_word(input logic [63:0] d);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        din       = d;
        din_valid = 1'b1;
        while (!ok && n < 200) begin
            #1;
            if (din_ready) ok = 1'b1;
            @(negedge clk);
            n++;
        end
        din_valid = 1'b0;
        if (!ok) chk_val("din_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_msg(input logic m, input int len, output int ep, output int el);
        int nw;
        nw = ((len & ~7) + 63) / 64;
        words.delete();
        for (int i = 0; i < nw; i++) begin
            if (m === 1'bx) words.push_back('0);
            else words.push_back({$urandom, $urandom});
        end
        build_exp(m, len, ep, el);
    endtask

    task automatic run_msg(input string nm, input logic m, input int len, input bit ones,
                           input int stall_at, input int stall_n, input int pdel);
        int ep;
        int el;
        int nw;
        bit got;
        int rate;
        rate = m ? 17 : 21;
        nw = ((len & ~7) + 63) / 64;
        words.delete();
        for (int i = 0; i < nw; i++) begin
            if (ones) words.push_back('1);
            else words.push_back({$urandom, $urandom});
        end
        build_exp(m, len, ep, el);
        perm_seen  = 0;
        lane_cnt   = 0;
        perm_delay = pdel;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word({32'h0, 32'(len)});
        for (int i = 0; i < nw; i++) begin
            if (i == stall_at) begin
                for (int c = 0; c < stall_n; c++) begin
                    #1;
                    chk_val({nm, "_stall_we"}, 64'(lane_we), 64'd0);
                    chk_val({nm, "_stall_idx"}, 64'(lane_idx), 64'(stall_at % rate));
                    @(negedge clk);
                end
            end
            send_word(words[i]);
        end
        got = 1'b0;
        #1;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk_val({nm, "_done"}, 64'(got), 64'd1);
        @(negedge clk);
        #1;
        chk_val({nm, "_done_pulse"}, 64'({done, busy}), 64'd0);
        chk_val({nm, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        chk_val({nm, "_perms"}, 64'(perm_seen), 64'(ep));
        chk_val({nm, "_lanes"}, 64'(lane_cnt), 64'(el));
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int ep;
        int el;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_val("rst_busy", 64'(busy), 64'd0);
        chk_val("rst_din_ready", 64'(din_ready), 64'd0);
        chk_val("rst_lane_we", 64'(lane_we), 64'd0);
        chk_val("rst_perm_start", 64'(perm_start), 64'd0);
        chk_val("rst_done", 64'(done), 64'd0);
        chk_val("rst_lane_data", lane_data, 64'd0);
        chk_val("rst_lane_idx", 64'(lane_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Empty message with same-cycle perm_done
        run_msg("s1", 1'b0, 0, 1'b1, -1, 0, 0);
        chk_val("s1_first", first_lane, 64'h0000_0000_0000_001F);
        chk_val("s1_last", last_lane, 64'h8000_0000_0000_0000);

        run_msg("s2", 1'b1, 24, 1'b1, -1, 0, 2);
        chk_val("s2_first", first_lane, 64'h0000_0000_1FFF_FFFF);
        chk_val("s2_last", last_lane, 64'h8000_0000_0000_0000);

        run_msg("s3", 1'b1, 1080, 1'b1, -1, 0, 2);
        chk_val("s3_last", last_lane, 64'h9FFF_FFFF_FFFF_FFFF);
        chk_val("s3_perms", 64'(perm_seen), 64'd1);

        run_msg("s4", 1'b0, 1344, 1'b0, -1, 0, 3);
        chk_val("s4_perms", 64'(perm_seen), 64'd2);
        chk_val("s4_last", last_lane, 64'h8000_0000_0000_0000);

        // Backpressure mid-block plus a slow permutation
        run_msg("s5", 1'b1, 1080, 1'b0, 5, 5, 30);

        // Odd-length message: low three length bits are discarded
        run_msg("s5b", 1'b0, 203, 1'b0, -1, 0, 1);

        // Reset while lane 7 is being absorbed
        start_msg(1'b0, 1344, ep, el);
        perm_delay = 2;
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word({32'h0, 32'd1344});
        for (int i = 0; i < 7; i++) send_word(words[i]);
        #1;
        chk_val("s6_idx7", 64'(lane_idx), 64'd7);
        chk_val("s6_busy_pre", 64'(busy), 64'd1);
        din       = words[7];
        din_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk_val("s6_rst_busy", 64'(busy), 64'd0);
        chk_val("s6_rst_we", 64'(lane_we), 64'd0);
        chk_val("s6_rst_ready", 64'(din_ready), 64'd0);
        din_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_msg("s6", 1'b0, 0, 1'b1, -1, 0, 0);
        chk_val("s6_first", first_lane, 64'h0000_0000_0000_001F);
        chk_val("s6_last", last_lane, 64'h8000_0000_0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
